// File: rtl/iob_cache_native.sv
// Set-associative write-through / no-write-allocate cache. CPU valid/ready port in front, native
// valid/ready memory port behind; writes go to memory through a FIFO write-through buffer.
module iob_cache_native #(
  parameter int unsigned FE_ADDR_W     = 32,
  parameter int unsigned FE_DATA_W     = 32,
  parameter int unsigned N_WAYS        = 2,
  parameter int unsigned LINE_OFF_W    = 4,
  parameter int unsigned WORD_OFF_W    = 2,
  parameter int unsigned BE_ADDR_W     = 32,
  parameter int unsigned BE_DATA_W     = 32,
  parameter int unsigned REP_POLICY    = 0,
  parameter int unsigned WTBUF_DEPTH_W = 4,
  parameter int unsigned CTRL_CACHE    = 0
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     valid,
  input  logic [FE_ADDR_W-$clog2(FE_DATA_W/8)-1:0] addr,
  input  logic [FE_DATA_W-1:0]                     wdata,
  input  logic [FE_DATA_W/8-1:0]                   wstrb,
  output logic [FE_DATA_W-1:0]                     rdata,
  output logic                                     ready,
  input  logic                                     force_inv_in,
  output logic                                     force_inv_out,
  input  logic                                     wtb_empty_in,
  output logic                                     wtb_empty_out,
  output logic [BE_ADDR_W-1:0]                     mem_addr,
  output logic [BE_DATA_W-1:0]                     mem_wdata,
  output logic [BE_DATA_W/8-1:0]                   mem_wstrb,
  input  logic [BE_DATA_W-1:0]                     mem_rdata,
  output logic                                     mem_valid,
  input  logic                                     mem_ready
);
  localparam int unsigned NBytes   = FE_DATA_W / 8;
  localparam int unsigned ByteW    = $clog2(NBytes);
  localparam int unsigned AddrW    = FE_ADDR_W - ByteW;
  localparam int unsigned TagW     = AddrW - LINE_OFF_W - WORD_OFF_W;
  localparam int unsigned NSets    = 2 ** LINE_OFF_W;
  localparam int unsigned NWords   = 2 ** WORD_OFF_W;
  localparam int unsigned WayW     = (N_WAYS > 1) ? $clog2(N_WAYS) : 1;
  localparam int unsigned WtbDepth = 2 ** WTBUF_DEPTH_W;

  typedef enum logic [1:0] {StIdle, StWait, StFill} state_e;
  state_e state_q, state_d;

  logic [N_WAYS-1:0]        valid_q [NSets];
  logic [TagW-1:0]          tag_q   [NSets][N_WAYS];
  logic [WayW-1:0]          age_q   [NSets][N_WAYS];
  logic [WayW-1:0]          rr_q    [NSets];
  logic [FE_DATA_W-1:0]     data_q  [NSets][N_WAYS][NWords];

  logic [AddrW-1:0]         wtb_addr_q [WtbDepth];
  logic [FE_DATA_W-1:0]     wtb_data_q [WtbDepth];
  logic [NBytes-1:0]        wtb_strb_q [WtbDepth];
  logic [WTBUF_DEPTH_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [WTBUF_DEPTH_W:0]   wtb_cnt_q;

  logic [AddrW-1:0]         addr_q;
  logic [WayW-1:0]          victim_q;
  logic [WORD_OFF_W-1:0]    fill_cnt_q;
  logic                     ready_q;
  logic [FE_DATA_W-1:0]     rdata_q;

  logic [LINE_OFF_W-1:0] idx, fidx, touch_idx;
  logic [TagW-1:0]       tag, ftag;
  logic [WORD_OFF_W-1:0] off, foff;
  logic [WayW-1:0]       hit_way, victim, max_age, touch_way;
  logic hit, is_write, accept, rd_req, push, pop, wtb_empty, wtb_full, rd_hit, wr_hit;
  logic fill_start, fill_beat, fill_done, touch, force_inv;

  // Front-end address decodes at acceptance; the latched copy drives the line fill.
  assign idx  = addr[WORD_OFF_W +: LINE_OFF_W];
  assign tag  = addr[AddrW-1 -: TagW];
  assign off  = addr[WORD_OFF_W-1:0];
  assign fidx = addr_q[WORD_OFF_W +: LINE_OFF_W];
  assign ftag = addr_q[AddrW-1 -: TagW];
  assign foff = addr_q[WORD_OFF_W-1:0];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    victim  = '0;
    max_age = age_q[idx][0];
    for (int w = 0; w < N_WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WayW'(w);
      end
    end
    if (REP_POLICY == 1) begin
      victim = rr_q[idx];
    end else begin
      for (int w = 1; w < N_WAYS; w++) begin
        if (age_q[idx][w] > max_age) begin
          max_age = age_q[idx][w];
          victim  = WayW'(w);
        end
      end
    end
    // Lowest-numbered invalid way overrides the replacement choice.
    for (int w = N_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) victim = WayW'(w);
    end
  end

  assign wtb_empty  = (wtb_cnt_q == '0);
  assign wtb_full   = (wtb_cnt_q == (WTBUF_DEPTH_W + 1)'(WtbDepth));
  assign pop        = (state_q != StFill) && !wtb_empty && mem_ready;
  assign accept     = valid && (state_q == StIdle);
  assign is_write   = |wstrb;
  assign rd_req     = accept && !is_write;
  assign push       = accept && is_write && (!wtb_full || pop);
  assign rd_hit     = rd_req && hit;
  assign wr_hit     = push && hit;
  assign fill_start = (state_q == StWait) && wtb_empty;
  assign fill_beat  = (state_q == StFill) && mem_ready;
  assign fill_done  = fill_beat && (fill_cnt_q == WORD_OFF_W'(NWords - 1));
  assign touch      = fill_done || rd_hit || wr_hit;
  assign touch_way  = fill_done ? victim_q : hit_way;
  assign touch_idx  = fill_done ? fidx : idx;
  assign force_inv  = (CTRL_CACHE != 0) && force_inv_in;

  assign force_inv_out = force_inv_in;
  assign wtb_empty_out = wtb_empty && ((CTRL_CACHE == 0) || wtb_empty_in);
  assign ready         = ready_q;
  assign rdata         = rdata_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (rd_req && !hit) state_d = StWait;
      StWait:  if (wtb_empty) state_d = StFill;
      StFill:  if (fill_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Line fills own the memory port; otherwise the buffer head drains.
  always_comb begin
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (state_q == StFill) begin
      mem_valid = 1'b1;
      mem_addr  = BE_ADDR_W'({addr_q[AddrW-1:WORD_OFF_W], fill_cnt_q, {ByteW{1'b0}}});
    end else if (!wtb_empty) begin
      mem_valid = 1'b1;
      mem_addr  = BE_ADDR_W'({wtb_addr_q[rd_ptr_q], {ByteW{1'b0}}});
      mem_wdata = wtb_data_q[rd_ptr_q];
      mem_wstrb = wtb_strb_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      addr_q     <= '0;
      victim_q   <= '0;
      fill_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wtb_cnt_q  <= '0;
      for (int s = 0; s < NSets; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
        for (int w = 0; w < N_WAYS; w++) begin
          age_q[s][w] <= '0;
          tag_q[s][w] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      ready_q <= rd_hit || push || fill_done;
      if (rd_hit) rdata_q <= data_q[idx][hit_way][off];
      if (fill_done) rdata_q <= (foff == fill_cnt_q) ? mem_rdata : data_q[fidx][victim_q][foff];
      if (rd_req && !hit) begin
        addr_q   <= addr;
        victim_q <= victim;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) wtb_cnt_q <= wtb_cnt_q + 1'b1;
      else if (pop && !push) wtb_cnt_q <= wtb_cnt_q - 1'b1;
      if (fill_start) begin
        fill_cnt_q              <= '0;
        valid_q[fidx][victim_q] <= 1'b0;
      end
      if (fill_beat) fill_cnt_q <= fill_cnt_q + 1'b1;
      if (fill_done) begin
        valid_q[fidx][victim_q] <= 1'b1;
        tag_q[fidx][victim_q]   <= ftag;
        if (N_WAYS > 1) rr_q[fidx] <= victim_q + 1'b1;
      end
      // Touched way becomes age 0; ways that were at most as old move one step older.
      if (touch) begin
        for (int w = 0; w < N_WAYS; w++) begin
          if (WayW'(w) == touch_way) begin
            age_q[touch_idx][w] <= '0;
          end else if (age_q[touch_idx][w] <= age_q[touch_idx][touch_way] &&
                       age_q[touch_idx][w] < WayW'(N_WAYS - 1)) begin
            age_q[touch_idx][w] <= age_q[touch_idx][w] + 1'b1;
          end
        end
      end
      if (force_inv) begin
        for (int s = 0; s < NSets; s++) valid_q[s] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_beat) data_q[fidx][victim_q][fill_cnt_q] <= mem_rdata;
    if (wr_hit) begin
      for (int b = 0; b < NBytes; b++) begin
        if (wstrb[b]) data_q[idx][hit_way][off][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (push) begin
      wtb_addr_q[wr_ptr_q] <= addr;
      wtb_data_q[wr_ptr_q] <= wdata;
      wtb_strb_q[wr_ptr_q] <= wstrb;
    end
  end

endmodule

// File: tb/tb_iob_cache_native.sv
// Scoreboard bench: a flat golden memory plus a per-set tag recency list predict read data,
// hit/miss latency and final memory contents; a monitor checks every ready pulse.
module tb_iob_cache_native;
  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic        force_inv_in, force_inv_out, wtb_empty_in, wtb_empty_out;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_valid, mem_ready;

  iob_cache_native dut (
    .clk(clk), .reset(reset), .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready), .force_inv_in(force_inv_in), .force_inv_out(force_inv_out),
    .wtb_empty_in(wtb_empty_in), .wtb_empty_out(wtb_empty_out), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_rd;
    logic [31:0] a;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  int unsigned cset [16][$];  // per-set tags, index 0 = most recently used
  logic [31:0] gold [1024];
  logic [31:0] mem_model [1024];
  int          n_checks = 0;
  int          n_fail = 0;
  int          mem_writes = 0;
  int          max_delay = 0;
  bit          mem_hold = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Two-way LRU cache contents as seen from outside; returns whether the access hits.
  function automatic bit model_access(input int unsigned a, input bit is_rd);
    int unsigned s = (a >> 2) & 15;
    int unsigned t = a >> 6;
    for (int i = 0; i < cset[s].size(); i++) begin
      if (cset[s][i] == t) begin
        cset[s].delete(i);
        cset[s].push_front(t);
        return 1'b1;
      end
    end
    if (is_rd) begin
      cset[s].push_front(t);
      if (cset[s].size() > 2) void'(cset[s].pop_back());
    end
    return 1'b0;
  endfunction

  // Memory responder: random delay per transaction, optional hold.
  initial begin
    int unsigned wi;
    int          wait_cnt;
    int          delay;
    mem_ready = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    delay     = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ready) begin
        mem_ready = 1'b0;
      end else if (mem_valid && !reset && !mem_hold) begin
        if (wait_cnt < delay) begin
          wait_cnt++;
        end else begin
          wait_cnt  = 0;
          delay     = $urandom_range(0, max_delay);
          mem_ready = 1'b1;
          wi        = int'(mem_addr[11:2]);
          if (mem_wstrb != 4'h0) begin
            for (int b = 0; b < 4; b++)
              if (mem_wstrb[b]) mem_model[wi][8*b +: 8] = mem_wdata[8*b +: 8];
            mem_writes++;
          end else begin
            mem_rdata = mem_model[wi];
          end
        end
      end
    end
  end

  // Monitor: every ready pulse consumes one expected response.
  always @(negedge clk) begin
    sb_t e;
    if (!reset && ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_ready: got ready with no request pending, expected none");
      end else begin
        e = sb_q.pop_front();
        if (e.is_rd) check($sformatf("rdata[%0d]", e.a), rdata, e.exp);
      end
    end
  end

  task automatic do_req(input int unsigned a, input logic [31:0] d, input logic [3:0] s,
                        input bit chk_lat, output int cyc);
    sb_t e;
    bit  exp_hit;
    exp_hit = model_access(a, s == 4'h0);
    e.is_rd = (s == 4'h0);
    e.a     = a;
    e.exp   = gold[a];
    for (int b = 0; b < 4; b++)
      if (s[b]) gold[a][8*b +: 8] = d[8*b +: 8];
    sb_q.push_back(e);
    valid = 1'b1;
    addr  = 30'(a);
    wdata = d;
    wstrb = s;
    cyc   = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!ready && cyc < 300);
    valid = 1'b0;
    wstrb = 4'h0;
    if (!ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout[%0d]: no ready after %0d cycles, required within 300", a, cyc);
    end else if (chk_lat) begin
      if (s != 4'h0 || exp_hit) check($sformatf("latency_1[%0d]", a), cyc, 1);
      else check($sformatf("miss_latency_gt1[%0d]", a), 32'(cyc > 1), 1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (!(wtb_empty_out && !mem_valid) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wtb_drained", 32'(wtb_empty_out && !mem_valid), 1);
  endtask

  task automatic check_mem(input int unsigned lo, input int unsigned hi);
    for (int unsigned i = lo; i <= hi; i++) check($sformatf("mem[%0d]", i), mem_model[i], gold[i]);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    int w0;
    for (int i = 0; i < 1024; i++) begin
      gold[i]      = '0;
      mem_model[i] = '0;
    end
    reset = 1'b1; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    force_inv_in = 1'b0; wtb_empty_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_ready", 32'(ready), 0);
    check("reset_mem_valid", 32'(mem_valid), 0);
    check("reset_rdata", rdata, 0);
    check("reset_wtb_empty", 32'(wtb_empty_out), 1);
    check("reset_force_inv_out", 32'(force_inv_out), 0);

    max_delay = 2;
    for (int i = 1; i <= 9; i++) do_req(i, 32'(i), 4'hF, 1, cyc);
    drain();
    check_mem(1, 9);
    for (int i = 0; i <= 9; i++) do_req(i, '0, 4'h0, 1, cyc);

    for (int i = 1; i <= 10; i++) do_req(i, 32'(i + 10), 4'hF, 1, cyc);
    for (int i = 0; i <= 10; i++) do_req(i, '0, 4'h0, 1, cyc);
    drain();
    check_mem(0, 10);

    do_req(0, 32'd57005, 4'hF, 1, cyc);
    do_req(0, '0, 4'h0, 1, cyc);
    do_req(19, 32'hDEAD_BEEF, 4'hF, 1, cyc);
    do_req(19, '0, 4'h0, 1, cyc);
    do_req(64, '0, 4'h0, 1, cyc);
    do_req(128, '0, 4'h0, 1, cyc);
    do_req(0, '0, 4'h0, 1, cyc);
    do_req(128, '0, 4'h0, 1, cyc);
    do_req(64, '0, 4'h0, 1, cyc);
    for (int i = 4; i <= 10; i++) do_req(i, '0, 4'h0, 1, cyc);
    do_req(5, 32'h1234_5678, 4'b0101, 1, cyc);
    do_req(5, '0, 4'h0, 1, cyc);

    // Full write-through buffer: the 17th write waits until memory pops one entry.
    drain();
    mem_hold = 1'b1;
    for (int i = 0; i < 16; i++) do_req(200 + i, 32'hA000_0000 + 32'(i), 4'hF, 1, cyc);
    w0 = mem_writes;
    fork
      begin
        repeat (8) @(posedge clk);
        mem_hold = 1'b0;
      end
      do_req(216, 32'hA5A5_0016, 4'hF, 0, cyc);
    join
    check("full_stall_cycles_ge8", 32'(cyc >= 8), 1);
    check("pop_before_ready", 32'(mem_writes > w0), 1);
    drain();
    check_mem(200, 216);

    max_delay = 3;
    for (int n = 0; n < 300; n++) begin
      int unsigned a = $urandom_range(0, 127);
      bit          rd = $urandom_range(0, 1) == 1;
      logic [3:0]  s = rd ? 4'h0 : 4'($urandom_range(1, 15));
      do_req(a, $urandom, s, rd, cyc);
    end
    drain();
    check_mem(0, 127);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
